wb_dbg_master_b3: RTL and testbench

Single-transaction Wishbone B3 classic-cycle initiator that turns one latched request from a debug/host request port into a complete bus cycle on a `wishbone_b3.master` port. It sits upstream of `wb_trafficcop_b3` and occupies one of its master slots. It handles `ack`/`err`/`rty` termination, bounded retry with back-off, and a watchdog timeout, then returns read data and a status code.

---
 rtl/wb_master_pkg.sv | 29 ++
 rtl/wishbone_b3.sv | 31 +++
 rtl/wb_cycle_timer.sv | 44 ++++
 rtl/wb_dbg_master_b3.sv | 213 +++++++++++++++++++++
 tb/tb_wb_dbg_master_b3.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared types and constants for the Wishbone B3 debug initiator.
//   wb_status_t : completion code returned alongside rsp_valid.
//   state_t     : top-level bus-cycle FSM states.
//   CTI_CLASSIC : cycle-type identifier for classic (non-burst) cycles.
//   cnt_width() : bit width needed to hold 0..n, never less than 1.
package wb_master_pkg;

    typedef enum logic [1:0] {
        WB_OK      = 2'd0,
        WB_ERR     = 2'd1,
        WB_RTY     = 2'd2,
        WB_TIMEOUT = 2'd3
    } wb_status_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CYCLE   = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // A zero-width counter is illegal, so small ranges round up to one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wishbone_b3.sv
// wishbone_b3: Wishbone B3 classic-cycle bus bundle.
//   master modport: drives adr, cyc, stb, we, sel, dat_m2s, cti, bte;
//                   samples ack, err, rty, dat_s2m.
//   slave modport : the mirror image.
interface wishbone_b3 #(
    parameter int addr_width = 32,
    parameter int data_width = 32
);
    logic [addr_width-1:0] adr;
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [3:0]            sel;
    logic [data_width-1:0] dat_m2s;
    logic [data_width-1:0] dat_s2m;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output adr, cyc, stb, we, sel, dat_m2s, cti, bte,
        input  ack, err, rty, dat_s2m
    );

    modport slave (
        input  adr, cyc, stb, we, sel, dat_m2s, cti, bte,
        output ack, err, rty, dat_s2m
    );
endinterface

// File: rtl/wb_cycle_timer.sv
// wb_cycle_timer: loadable down-counter that saturates at zero.
//   clk, rst_n : clock and asynchronous active-low reset.
//   load       : load load_val this cycle (wins over dec).
//   load_val   : value to load.
//   dec        : decrement by one unless already zero.
//   zero       : count is zero.
module wb_cycle_timer #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [width-1:0] count_q;
    logic [width-1:0] count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - width'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/wb_dbg_master_b3.sv
// wb_dbg_master_b3: single-transaction Wishbone B3 classic-cycle initiator.
// Latches one request, runs it on the bus with ack/err/rty handling, bounded
// retry with back-off and a watchdog timeout, then pulses rsp_valid.
//   clk, rst_n  : clock, asynchronous active-low reset.
//   req_stb     : request strobe, sampled only while req_busy is low.
//   req_we/adr/dat/sel : request attributes.
//   req_busy    : transaction in progress.
//   rsp_valid   : one-cycle completion pulse.
//   rsp_dat     : read data (updated only by an acked read).
//   rsp_status  : completion code, valid with rsp_valid.
//   wb          : Wishbone B3 master port.
module wb_dbg_master_b3
    import wb_master_pkg::*;
#(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int max_retries    = 3,
    parameter int backoff_cycles = 4,
    parameter int timeout_cycles = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_stb,
    input  logic                  req_we,
    input  logic [addr_width-1:0] req_adr,
    input  logic [data_width-1:0] req_dat,
    input  logic [3:0]            req_sel,
    output logic                  req_busy,
    output logic                  rsp_valid,
    output logic [data_width-1:0] rsp_dat,
    output wb_status_t            rsp_status,
    wishbone_b3.master            wb
);

    localparam int  TO_W       = cnt_width(timeout_cycles);
    localparam int  BO_W       = cnt_width(backoff_cycles);
    localparam int  RT_W       = cnt_width(max_retries);
    localparam bit  TIMEOUT_EN = (timeout_cycles != 0);
    // Timers count down to zero, so they load N-1 to expire on the N-th cycle.
    localparam int  TO_LOAD_I  = (timeout_cycles > 0) ? timeout_cycles - 1 : 0;
    localparam int  BO_LOAD_I  = (backoff_cycles > 0) ? backoff_cycles - 1 : 0;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_LOAD_I);
    localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BO_LOAD_I);
    localparam logic [RT_W-1:0] RT_LOAD = RT_W'(max_retries);

    state_t                state_q,      state_d;
    logic                  cyc_q,        cyc_d;
    logic                  busy_q,       busy_d;
    logic                  we_q,         we_d;
    logic [addr_width-1:0] adr_q,        adr_d;
    logic [data_width-1:0] dat_q,        dat_d;
    logic [3:0]            sel_q,        sel_d;
    logic [RT_W-1:0]       retry_q,      retry_d;
    logic                  rsp_valid_q,  rsp_valid_d;
    logic [data_width-1:0] rsp_dat_q,    rsp_dat_d;
    wb_status_t            rsp_status_q, rsp_status_d;

    logic to_load, to_dec, to_zero;
    logic bo_load, bo_dec, bo_zero;

    // Watchdog: counts strobe cycles of the current phase.
    wb_cycle_timer #(.width(TO_W)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (to_load),
        .load_val (TO_LOAD),
        .dec      (to_dec),
        .zero     (to_zero)
    );

    // Back-off: counts idle cycles between a rty and the re-issue.
    wb_cycle_timer #(.width(BO_W)) u_backoff (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bo_load),
        .load_val (BO_LOAD),
        .dec      (bo_dec),
        .zero     (bo_zero)
    );

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        busy_d       = busy_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        retry_d      = retry_q;
        rsp_valid_d  = 1'b0;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        to_load      = 1'b0;
        to_dec       = 1'b0;
        bo_load      = 1'b0;
        bo_dec       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_stb) begin
                    we_d    = req_we;
                    adr_d   = req_adr;
                    dat_d   = req_dat;
                    sel_d   = req_sel;
                    retry_d = RT_LOAD;
                    to_load = 1'b1;
                    cyc_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_CYCLE;
                end
            end

            ST_CYCLE: begin
                // Priority err > ack > rty > timeout.
                if (wb.err) begin
                    cyc_d        = 1'b0;
                    busy_d       = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = WB_ERR;
                    state_d      = ST_IDLE;
                end else if (wb.ack) begin
                    if (!we_q) begin
                        rsp_dat_d = wb.dat_s2m;
                    end
                    cyc_d        = 1'b0;
                    busy_d       = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = WB_OK;
                    state_d      = ST_IDLE;
                end else if (wb.rty) begin
                    cyc_d = 1'b0;
                    if (retry_q != '0) begin
                        retry_d = retry_q - RT_W'(1);
                        bo_load = 1'b1;
                        state_d = ST_BACKOFF;
                    end else begin
                        busy_d       = 1'b0;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = WB_RTY;
                        state_d      = ST_IDLE;
                    end
                end else if (TIMEOUT_EN && to_zero) begin
                    cyc_d        = 1'b0;
                    busy_d       = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = WB_TIMEOUT;
                    state_d      = ST_IDLE;
                end else begin
                    to_dec = 1'b1;
                end
            end

            ST_BACKOFF: begin
                if (bo_zero) begin
                    cyc_d   = 1'b1;
                    to_load = 1'b1;
                    state_d = ST_CYCLE;
                end else begin
                    bo_dec = 1'b1;
                end
            end

            default: begin
                cyc_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            retry_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= WB_OK;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            busy_q       <= busy_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            retry_q      <= retry_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign wb.cyc     = cyc_q;
    assign wb.stb     = cyc_q;
    assign wb.we      = we_q;
    assign wb.adr     = adr_q;
    assign wb.sel     = sel_q;
    assign wb.dat_m2s = dat_q;
    assign wb.cti     = CTI_CLASSIC;
    assign wb.bte     = BTE_LINEAR;

    assign req_busy   = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_wb_dbg_master_b3.sv
// tb_wb_dbg_master_b3: directed self-checking bench for wb_dbg_master_b3
// (max_retries=3, backoff_cycles=4, timeout_cycles=8) with a scripted slave.
module tb_wb_dbg_master_b3;
    import wb_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_stb;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        req_busy;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    wb_status_t  rsp_status;

    wishbone_b3 #(.addr_width(32), .data_width(32)) wb ();

    wb_dbg_master_b3 #(
        .addr_width     (32),
        .data_width     (32),
        .max_retries    (3),
        .backoff_cycles (4),
        .timeout_cycles (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_stb    (req_stb),
        .req_we     (req_we),
        .req_adr    (req_adr),
        .req_dat    (req_dat),
        .req_sel    (req_sel),
        .req_busy   (req_busy),
        .rsp_valid  (rsp_valid),
        .rsp_dat    (rsp_dat),
        .rsp_status (rsp_status),
        .wb         (wb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave script: phases before rty_phases end with rty, later ones with ack
    // (plus err if err_too); each phase terminates after wait_states waits.
    int          wait_states = 0;
    int          rty_phases  = 0;
    bit          err_too     = 1'b0;
    bit          silent      = 1'b0;
    logic [31:0] slv_dat     = '0;
    int          stb_cnt     = 0;
    int          phase_idx   = 0;
    logic        term_now;

    always_comb begin
        term_now   = wb.cyc && wb.stb && !silent && (stb_cnt == wait_states);
        wb.rty     = term_now && (phase_idx < rty_phases);
        wb.ack     = term_now && (phase_idx >= rty_phases);
        wb.err     = term_now && err_too && (phase_idx >= rty_phases);
        wb.dat_s2m = slv_dat;
    end

    always @(posedge clk) begin
        if (!req_busy) begin
            stb_cnt   <= 0;
            phase_idx <= 0;
        end else if (wb.cyc) begin
            if (term_now) begin
                stb_cnt   <= 0;
                phase_idx <= phase_idx + 1;
            end else begin
                stb_cnt <= stb_cnt + 1;
            end
        end
    end

    // Bus monitor: running totals; tests compare deltas.
    logic [31:0] exp_adr = '0;
    logic [31:0] exp_dat = '0;
    logic [3:0]  exp_sel = '0;
    logic        exp_we  = 1'b0;
    int cyc_total  = 0;
    int rise_total = 0;
    int gap_total  = 0;
    int bad_gap    = 0;
    int gap_run    = 0;
    int rsp_total  = 0;
    int stab_viol  = 0;
    logic cyc_prev = 1'b0;

    always @(posedge clk) begin
        if (req_busy && !wb.cyc) begin
            gap_run <= gap_run + 1;
        end else if (wb.cyc && gap_run != 0) begin
            gap_total <= gap_total + 1;
            if (gap_run != 4) bad_gap <= bad_gap + 1;
            gap_run <= 0;
        end
        if (wb.cyc) cyc_total <= cyc_total + 1;
        if (wb.cyc && !cyc_prev) rise_total <= rise_total + 1;
        cyc_prev <= wb.cyc;
        if (rsp_valid) rsp_total <= rsp_total + 1;
        if (req_busy && (wb.adr != exp_adr || wb.dat_m2s != exp_dat ||
                         wb.sel != exp_sel || wb.we != exp_we))
            stab_viol <= stab_viol + 1;
    end

    // Issues one request and waits (bounded) for rsp_valid. lat counts edges
    // from the sampling edge to the edge that raised rsp_valid.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit poke,
                           output logic [1:0] st, output logic [31:0] rdat, output int lat);
        bit done = 1'b0;
        exp_adr = adr;
        exp_dat = dat;
        exp_sel = sel;
        exp_we  = we;
        @(negedge clk);
        req_stb = 1'b1;
        req_we  = we;
        req_adr = adr;
        req_dat = dat;
        req_sel = sel;
        @(negedge clk);
        req_stb = 1'b0;
        req_adr = ~adr;
        req_dat = ~dat;
        req_sel = ~sel;
        req_we  = ~we;
        check("busy_start", {63'd0, req_busy}, 64'd1);
        check("cyc_start", {62'd0, wb.cyc, wb.stb}, 64'd3);
        lat = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 1) begin
                req_stb = 1'b1;
                req_adr = 32'h0000_0999;
            end
            if (poke && lat == 2) req_stb = 1'b0;
            if (rsp_valid) done = 1'b1;
        end
        req_stb = 1'b0;
        if (!done) check("rsp_seen", 64'd0, 64'd1);
        st   = rsp_status;
        rdat = rsp_dat;
        check("busy_end", {63'd0, req_busy}, 64'd0);
        check("cyc_end", {63'd0, wb.cyc}, 64'd0);
        @(negedge clk);
        check("rsp_pulse", {63'd0, rsp_valid}, 64'd0);
    endtask

    logic [1:0]  st;
    logic [31:0] rdat;
    int          lat;
    int          c0, r0, g0, b0, v0, s0;

    task automatic snap();
        c0 = cyc_total; r0 = rise_total; g0 = gap_total;
        b0 = bad_gap;   v0 = rsp_total;  s0 = stab_viol;
    endtask

    initial begin
        rst_n   = 1'b0;
        req_stb = 1'b0;
        req_we  = 1'b0;
        req_adr = '0;
        req_dat = '0;
        req_sel = '0;
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_cyc_stb_we", {61'd0, wb.cyc, wb.stb, wb.we}, 64'd0);
        check("rst_adr", {32'd0, wb.adr}, 64'd0);
        check("rst_sel", {60'd0, wb.sel}, 64'd0);
        check("rst_dat_m2s", {32'd0, wb.dat_m2s}, 64'd0);
        check("rst_busy_valid", {62'd0, req_busy, rsp_valid}, 64'd0);
        check("rst_rsp_dat", {32'd0, rsp_dat}, 64'd0);
        check("rst_status", {62'd0, rsp_status}, 64'(WB_OK));
        check("cti_bte", {59'd0, wb.cti, wb.bte}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait read.
        wait_states = 0; rty_phases = 0; err_too = 0; silent = 0;
        slv_dat = 32'hDEAD_BEEF;
        snap();
        run_txn(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, st, rdat, lat);
        check("zw_status", {62'd0, st}, 64'(WB_OK));
        check("zw_data", {32'd0, rdat}, 64'hDEAD_BEEF);
        check("zw_latency", 64'(lat), 64'd1);
        check("zw_strobes", 64'(cyc_total - c0), 64'd1);
        check("zw_stable", 64'(stab_viol - s0), 64'd0);

        // Write with 3 wait states; rsp_dat must keep the previous read data.
        wait_states = 3; slv_dat = 32'hBAD0_BAD0;
        snap();
        run_txn(1'b1, 32'h200, 32'h1234_5678, 4'b0011, 1'b0, st, rdat, lat);
        check("wr_status", {62'd0, st}, 64'(WB_OK));
        check("wr_rsp_dat", {32'd0, rdat}, 64'hDEAD_BEEF);
        check("wr_strobes", 64'(cyc_total - c0), 64'd4);
        check("wr_latency", 64'(lat), 64'd4);
        check("wr_stable", 64'(stab_viol - s0), 64'd0);

        // rty twice then ack: 3 phases, two 4-cycle gaps.
        wait_states = 0; rty_phases = 2; slv_dat = 32'hCAFE_0001;
        snap();
        run_txn(1'b0, 32'h300, 32'h0, 4'hF, 1'b0, st, rdat, lat);
        check("rty2_status", {62'd0, st}, 64'(WB_OK));
        check("rty2_data", {32'd0, rdat}, 64'hCAFE_0001);
        check("rty2_phases", 64'(rise_total - r0), 64'd3);
        check("rty2_gaps", 64'(gap_total - g0), 64'd2);
        check("rty2_gap_len", 64'(bad_gap - b0), 64'd0);
        check("rty2_latency", 64'(lat), 64'd11);
        check("rty2_stable", 64'(stab_viol - s0), 64'd0);

        // rty four times: retries exhausted after 4 phases.
        rty_phases = 4;
        snap();
        run_txn(1'b1, 32'h400, 32'h5555_AAAA, 4'b1000, 1'b0, st, rdat, lat);
        check("rty4_status", {62'd0, st}, 64'(WB_RTY));
        check("rty4_phases", 64'(rise_total - r0), 64'd4);
        check("rty4_gap_len", 64'(bad_gap - b0), 64'd0);
        check("rty4_latency", 64'(lat), 64'd16);

        // err and ack together: err wins, read data not captured.
        rty_phases = 0; err_too = 1; slv_dat = 32'h0BAD_0BAD;
        snap();
        run_txn(1'b0, 32'h500, 32'h0, 4'hF, 1'b0, st, rdat, lat);
        check("err_status", {62'd0, st}, 64'(WB_ERR));
        check("err_rsp_dat", {32'd0, rdat}, 64'hCAFE_0001);
        err_too = 0;

        // req_stb while busy is ignored.
        wait_states = 3; slv_dat = 32'h7777_1234;
        snap();
        run_txn(1'b0, 32'h600, 32'h0, 4'hF, 1'b1, st, rdat, lat);
        repeat (3) @(negedge clk);
        check("busy_status", {62'd0, st}, 64'(WB_OK));
        check("busy_data", {32'd0, rdat}, 64'h7777_1234);
        check("busy_one_cycle", 64'(rise_total - r0), 64'd1);
        check("busy_one_rsp", 64'(rsp_total - v0), 64'd1);
        check("busy_stable", 64'(stab_viol - s0), 64'd0);

        // Silent slave: timeout after exactly 8 strobe cycles.
        silent = 1;
        snap();
        run_txn(1'b0, 32'h700, 32'h0, 4'hF, 1'b0, st, rdat, lat);
        check("to_status", {62'd0, st}, 64'(WB_TIMEOUT));
        check("to_strobes", 64'(cyc_total - c0), 64'd8);
        check("to_latency", 64'(lat), 64'd8);

        // Reset in the middle of a strobe.
        snap();
        @(negedge clk);
        req_stb = 1'b1; req_we = 1'b0; req_adr = 32'h800; req_sel = 4'hF;
        exp_adr = 32'h800; exp_dat = req_dat; exp_sel = 4'hF; exp_we = 1'b0;
        @(negedge clk);
        req_stb = 1'b0;
        @(negedge clk);
        check("mid_cyc_before", {63'd0, wb.cyc}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc_stb", {62'd0, wb.cyc, wb.stb}, 64'd0);
        check("mid_rst_busy", {63'd0, req_busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_no_rsp", 64'(rsp_total - v0), 64'd0);

        // Next request proceeds normally.
        silent = 0; wait_states = 0; slv_dat = 32'h1357_9BDF;
        snap();
        run_txn(1'b0, 32'h900, 32'h0, 4'hF, 1'b0, st, rdat, lat);
        check("post_rst_status", {62'd0, st}, 64'(WB_OK));
        check("post_rst_data", {32'd0, rdat}, 64'h1357_9BDF);
        check("post_rst_latency", 64'(lat), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
